// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_MEM_TAG_WIDTH = 2;
  localparam int unsigned FETCH_WIDTH         = 32;
  localparam int unsigned FETCH_DEPTH         = 1024;
  localparam int unsigned FETCH_ADDR_W        = $clog2(FETCH_DEPTH * FETCH_WIDTH / 8);
  localparam int unsigned FETCH_BYTES         = FETCH_WIDTH / 8;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_WIDTH-1:0]  instr;
  } fetch_entry_t;

  function automatic int unsigned fetch_bytes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a registered head entry.
module fetch_fifo #(
  parameter int unsigned DATA_W = 44,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & (count_q != '0) & ~flush;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    head_valid_d = (count_d != '0);
    head_data_d  = '0;
    // The new head may be the entry being written on this very edge.
    if (count_d != '0) begin
      head_data_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
    end
  end

  assign head_valid = head_valid_q;
  assign head_data  = head_data_q;
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch requester: sequential PC generation, epoch-tagged iccm reads and a
// small instruction buffer feeding decode.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       WIDTH      = FETCH_WIDTH,
  parameter int unsigned       DEPTH      = FETCH_DEPTH,
  parameter int unsigned       ADDR_W     = $clog2(DEPTH * WIDTH / 8),
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       TAG_W      = INSTR_MEM_TAG_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_raddr,
  output logic              imem_req,
  output logic [TAG_W-1:0]  imem_tag,
  input  logic [WIDTH-1:0]  imem_rdata,
  input  logic              imem_rvalid,
  input  logic [TAG_W-1:0]  imem_rtag,
  output logic              inst_valid,
  output logic [WIDTH-1:0]  inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned FetchBytes = fetch_bytes(WIDTH);
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntryW     = ADDR_W + WIDTH;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(FetchBytes - 1);

  logic [ADDR_W-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d, ea;
  logic [TAG_W-1:0]  epoch_q, epoch_d, ep;
  logic              inflight_q, inflight_d;
  logic [CntW-1:0]   fifo_count, occ;
  logic              issue, accept, pop, head_valid;
  logic [EntryW-1:0] head_data;

  always_comb begin
    ea     = redirect_valid ? (redirect_pc & AlignMask) : pc_q;
    ep     = epoch_q + TAG_W'(redirect_valid);
    occ    = redirect_valid ? '0 : fifo_count;
    // Credit check counts the in-flight slot so the buffer can never overflow.
    issue  = fetch_en & ~rst & ((int'(occ) + int'(inflight_q)) < int'(FIFO_DEPTH));
    accept = imem_rvalid & inflight_q & (imem_rtag == epoch_q) & ~redirect_valid;
    pop    = head_valid & inst_ready & ~redirect_valid;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    epoch_d       = ep;
    if (issue) begin
      pc_d          = ea + ADDR_W'(FetchBytes);
      inflight_pc_d = ea;
    end else if (redirect_valid) begin
      pc_d = ea;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      epoch_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DATA_W (EntryW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (accept),
    .push_data  ({inflight_pc_q, imem_rdata}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign imem_req   = issue;
  assign imem_raddr = ea;
  assign imem_tag   = ep;
  assign inst_valid = head_valid;
  assign inst_pc    = head_data[EntryW-1:WIDTH];
  assign inst_data  = head_data[WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed scoreboard bench for instr_fetch_ctrl with a 1-cycle iccm responder model.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 1;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_raddr;
  logic          imem_req;
  logic [TW-1:0] imem_tag;
  logic [DW-1:0] imem_rdata;
  logic          imem_rvalid;
  logic [TW-1:0] imem_rtag;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  logic          inj;
  logic          corrupt;

  int n_cmp;
  int n_fail;
  fetch_entry_t exp_q[$];

  instr_fetch_ctrl #(
    .WIDTH      (DW),
    .DEPTH      (1024),
    .RESET_PC   (12'h100),
    .FIFO_DEPTH (4),
    .TAG_W      (TW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_raddr     (imem_raddr),
    .imem_req       (imem_req),
    .imem_tag       (imem_tag),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .imem_rtag      (imem_rtag),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {20'hC0DE5, a};
  endfunction

  // iccm model: answers every request one cycle later; inj forces a stray response,
  // corrupt flips the returned tag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_rvalid <= 1'b0;
      imem_rtag   <= '0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= imem_req | inj;
      imem_rtag   <= imem_req ? (corrupt ? ~imem_tag : imem_tag) : '0;
      imem_rdata  <= mdata(imem_raddr);
    end
  end

  always @(negedge clk) begin : monitor
    fetch_entry_t e;
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_entry: got pc=%h data=%h, required no entry", inst_pc, inst_data);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst_data !== e.instr) begin
          n_fail = n_fail + 1;
          $display("FAIL entry: got pc=%h data=%h, required pc=%h data=%h",
                   inst_pc, inst_data, e.pc, e.instr);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a);
    exp_q.push_back(fetch_entry_t'{pc: a, instr: mdata(a)});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req),   32'h0);
    chk({tag, "_raddr"}, 32'(imem_raddr), 32'h100);
    chk({tag, "_tag"},   32'(imem_tag),   32'h0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_data"},  inst_data,       32'h0);
    chk({tag, "_pc"},    32'(inst_pc),    32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inj = 1'b0;
    corrupt = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk_reset_outputs("reset");

    // Sequential streaming from RESET_PC.
    cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(AW'(12'h100 + 4 * i));
    #1; chk("c0_req", 32'(imem_req), 32'h1); chk("c0_raddr", 32'(imem_raddr), 32'h100);
    cyc(); #1; chk("c1_raddr", 32'(imem_raddr), 32'h104);
    cyc(); #1; chk("c2_raddr", 32'(imem_raddr), 32'h108);
    chk("c2_valid", 32'(inst_valid), 32'h1); chk("c2_pc", 32'(inst_pc), 32'h100);
    cyc();
    cyc(); fetch_en = 1'b0;
    cyc(3);

    // Backpressure: four entries fill, then one pop releases exactly one request.
    cyc(); fetch_en = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_exp(AW'(12'h110 + 4 * i));
    #1; chk("d0_raddr", 32'(imem_raddr), 32'h110);
    cyc(4); #1; chk("d4_req", 32'(imem_req), 32'h0);
    cyc(); #1; chk("d5_req", 32'(imem_req), 32'h0);
    chk("d5_valid", 32'(inst_valid), 32'h1); chk("d5_pc", 32'(inst_pc), 32'h110);
    cyc(); inst_ready = 1'b1; #1; chk("d6_req", 32'(imem_req), 32'h0);
    cyc(); inst_ready = 1'b0; #1;
    chk("d7_req", 32'(imem_req), 32'h1); chk("d7_raddr", 32'(imem_raddr), 32'h120);
    cyc(); #1; chk("d8_req", 32'(imem_req), 32'h0);
    cyc(); #1; chk("d9_req", 32'(imem_req), 32'h0);
    cyc(); inst_ready = 1'b1;
    cyc(); inst_ready = 1'b0; #1; chk("d11_raddr", 32'(imem_raddr), 32'h124);

    // Redirect with 3 buffered and 1 in flight.
    cyc(); redirect_valid = 1'b1; redirect_pc = 12'h200;
    exp_q.delete(); push_exp(12'h200); push_exp(12'h204);
    #1; chk("d12_req", 32'(imem_req), 32'h1); chk("d12_raddr", 32'(imem_raddr), 32'h200);
    chk("d12_tag", 32'(imem_tag), 32'h1);
    cyc(); redirect_valid = 1'b0; inst_ready = 1'b1;
    #1; chk("d13_valid", 32'(inst_valid), 32'h0); chk("d13_raddr", 32'(imem_raddr), 32'h204);
    cyc(); fetch_en = 1'b0;
    #1; chk("d14_valid", 32'(inst_valid), 32'h1); chk("d14_pc", 32'(inst_pc), 32'h200);
    cyc(4);

    // Misaligned redirect target; epoch wraps 1 -> 0.
    redirect_valid = 1'b1; redirect_pc = 12'h203; fetch_en = 1'b1; push_exp(12'h200);
    #1; chk("e0_raddr", 32'(imem_raddr), 32'h200); chk("e0_tag", 32'(imem_tag), 32'h0);
    cyc(); redirect_valid = 1'b0; fetch_en = 1'b0;
    cyc(); #1; chk("e2_valid", 32'(inst_valid), 32'h1); chk("e2_pc", 32'(inst_pc), 32'h200);
    cyc(3);

    // Stray response with nothing in flight, then a response carrying the wrong tag.
    inj = 1'b1;
    cyc(); inj = 1'b0;
    cyc(); #1; chk("f2_valid", 32'(inst_valid), 32'h0);
    cyc(); fetch_en = 1'b1; corrupt = 1'b1; #1; chk("g0_raddr", 32'(imem_raddr), 32'h204);
    cyc(); fetch_en = 1'b0; corrupt = 1'b0;
    cyc(); #1; chk("g2_valid", 32'(inst_valid), 32'h0);
    cyc(); #1; chk("g3_valid", 32'(inst_valid), 32'h0);

    // Asynchronous reset between edges while streaming.
    cyc(); fetch_en = 1'b1; inst_ready = 1'b1; push_exp(12'h208); push_exp(12'h20C);
    #1; chk("h0_raddr", 32'(imem_raddr), 32'h208);
    cyc();
    cyc(); #2; rst = 1'b1; exp_q.delete();
    #1; chk_reset_outputs("rst_mid");
    cyc(); rst = 1'b0; push_exp(12'h100);
    #1; chk("k0_req", 32'(imem_req), 32'h1); chk("k0_raddr", 32'(imem_raddr), 32'h100);
    cyc(); fetch_en = 1'b0;
    cyc(4);

    // Three back-to-back redirects with a 1-bit epoch.
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h300;
    push_exp(12'h380); push_exp(12'h384);
    #1; chk("j0_raddr", 32'(imem_raddr), 32'h300); chk("j0_tag", 32'(imem_tag), 32'h1);
    cyc(); redirect_pc = 12'h340;
    #1; chk("j1_raddr", 32'(imem_raddr), 32'h340); chk("j1_tag", 32'(imem_tag), 32'h0);
    cyc(); redirect_pc = 12'h380;
    #1; chk("j2_raddr", 32'(imem_raddr), 32'h380); chk("j2_tag", 32'(imem_tag), 32'h1);
    cyc(); redirect_valid = 1'b0;
    #1; chk("j3_raddr", 32'(imem_raddr), 32'h384); chk("j3_tag", 32'(imem_tag), 32'h1);
    cyc(); fetch_en = 1'b0;
    #1; chk("j4_valid", 32'(inst_valid), 32'h1); chk("j4_pc", 32'(inst_pc), 32'h380);
    cyc(5);

    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
